// File: rtl/sm83_irq_flags.sv
`default_nettype none
// ============================================================================
// Module      : sm83_irq_flags
// Description : Interrupt-flag register (IF, 0xFF0F). Latches rising edges of
//               the peripheral request lines as sticky flags, presents them to
//               the CPU core as irq[7:0], clears them on the one-hot iack from
//               the core, and gives the CPU read/write access at 0xFF0F.
//               A sticky per-source overflow bit records requests that
//               arrived while the same flag was still pending.
// Config      : INT_SRC_SYNC_EN - when defined, each src_req bit passes through
//               a 2-flop synchronizer before edge detection (3-cycle latency);
//               when undefined, src_req is taken as synchronous (1 cycle).
// Ports       : clk      - system clock, all state updates on posedge
//               reset_n  - asynchronous active-low reset
//               src_req  - peripheral request levels (rising edge = request)
//               irq      - pending flags to CPU, upper unimplemented bits 0
//               iack     - one-hot acknowledge pulse from CPU, clears flag
//               if_din   - CPU write data for 0xFF0F
//               if_we    - CPU write strobe (1 cycle)
//               if_dout  - CPU read data {UNUSED_RD fill, flags}
//               ovf      - sticky lost-request status, cleared by any write
// Revision    : 1.0 - initial release
// ============================================================================
module sm83_irq_flags #(
   parameter int   N_SRC     = 5,
   parameter logic UNUSED_RD = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] src_req,
   output logic [7:0]       irq,
   input  logic [7:0]       iack,
   input  logic [7:0]       if_din,
   input  logic             if_we,
   output logic [7:0]       if_dout,
   output logic [N_SRC-1:0] ovf
);

   logic [N_SRC-1:0] w_src_s;
   logic [N_SRC-1:0] w_set;
   logic [N_SRC-1:0] w_iack;
   logic [N_SRC-1:0] w_base;
   logic [N_SRC-1:0] w_flags_nxt;
   logic [N_SRC-1:0] w_ovf_nxt;

   logic [N_SRC-1:0] r_src_prev;
   logic [N_SRC-1:0] r_flags;
   logic [N_SRC-1:0] r_ovf;

`ifdef INT_SRC_SYNC_EN
   // Two-stage synchronizer per request bit for asynchronous peripherals.
   logic [N_SRC-1:0] r_sync1;
   logic [N_SRC-1:0] r_sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= src_req;
         r_sync2 <= r_sync1;
      end
   end

   assign w_src_s = r_sync2;
`else
   assign w_src_s = src_req;
`endif

   // Rising-edge detect: a level held high only ever produces one set.
   assign w_set  = w_src_s & ~r_src_prev;
   assign w_iack = iack[N_SRC-1:0];

   // Precedence is hardware set > acknowledge clear > CPU write: the write
   // replaces the base value, iack masks it, and set is OR-ed on top last.
   assign w_base      = if_we ? if_din[N_SRC-1:0] : r_flags;
   assign w_flags_nxt = (w_base & ~w_iack) | w_set;

   // A new edge on a flag that is already pending and not being acknowledged
   // this cycle means one request was merged into another. Recording it wins
   // over the clear-by-write in the same cycle.
   assign w_ovf_nxt = (if_we ? '0 : r_ovf) | (w_set & r_flags & ~w_iack);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_src_prev <= '0;
         r_flags    <= '0;
         r_ovf      <= '0;
      end else begin
         r_src_prev <= w_src_s;
         r_flags    <= w_flags_nxt;
         r_ovf      <= w_ovf_nxt;
      end
   end

   assign ovf = r_ovf;

   // Outputs come straight from registers; no combinational path from inputs.
   generate
      if (N_SRC == 8) begin : g_full
         assign irq     = r_flags;
         assign if_dout = r_flags;
      end else begin : g_partial
         assign irq     = {{(8 - N_SRC){1'b0}}, r_flags};
         assign if_dout = {{(8 - N_SRC){UNUSED_RD}}, r_flags};

         // Upper write-data and acknowledge bits have no flag behind them.
         logic w_unused_hi;
         assign w_unused_hi = ^{if_din[7:N_SRC], iack[7:N_SRC]};
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sm83_irq_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm83_irq_flags
// Description : Directed self-checking bench for sm83_irq_flags (N_SRC=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm83_irq_flags;

`ifdef INT_SRC_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk;
   logic       reset_n;
   logic [4:0] src_req;
   logic [7:0] irq;
   logic [7:0] iack;
   logic [7:0] if_din;
   logic       if_we;
   logic [7:0] if_dout;
   logic [4:0] ovf;

   int n_pass;
   int n_total;

   sm83_irq_flags #(
      .N_SRC     (5),
      .UNUSED_RD (1'b1)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .src_req (src_req),
      .irq     (irq),
      .iack    (iack),
      .if_din  (if_din),
      .if_we   (if_we),
      .if_dout (if_dout),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; returns 1 time unit after the last edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cpu_write(input logic [7:0] d);
      if_we  = 1'b1;
      if_din = d;
      tick(1);
      if_we  = 1'b0;
      if_din = 8'h00;
   endtask

   task automatic cleanup();
      src_req = 5'h00;
      iack    = 8'h00;
      tick(LAT + 1);
      cpu_write(8'h00);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      src_req = 5'h1F;
      iack    = 8'h00;
      if_din  = 8'h00;
      if_we   = 1'b0;
      tick(3);
      n_total++;
      if (irq !== 8'h00) $display("FAIL reset_irq: got %h want 00", irq);
      else n_pass++;
      n_total++;
      if (if_dout !== 8'hE0) $display("FAIL reset_dout: got %h want e0", if_dout);
      else n_pass++;
      n_total++;
      if (ovf !== 5'h00) $display("FAIL reset_ovf: got %h want 00", ovf);
      else n_pass++;
      reset_n = 1'b1;
      tick(LAT);
      n_total++;
      if (irq !== 8'h1F) $display("FAIL reset_release_irq: got %h want 1f", irq);
      else n_pass++;
      cleanup();
      n_total++;
      if (irq !== 8'h00) $display("FAIL reset_cleanup_irq: got %h want 00", irq);
      else n_pass++;
   endtask

   task automatic test_req_ack();
      src_req = 5'h04;
      #1;
      n_total++;
      if (irq !== 8'h00) $display("FAIL req_no_comb_path: got %h want 00", irq);
      else n_pass++;
      tick(LAT);
      n_total++;
      if (irq !== 8'h04) $display("FAIL req_latency: got %h want 04", irq);
      else n_pass++;
      iack = 8'h04;
      tick(1);
      iack = 8'h00;
      n_total++;
      if (irq !== 8'h00) $display("FAIL ack_clear: got %h want 00", irq);
      else n_pass++;
      tick(4);
      n_total++;
      if (irq !== 8'h00) $display("FAIL level_held_no_reset: got %h want 00", irq);
      else n_pass++;
      cleanup();
   endtask

   task automatic test_simultaneous();
      src_req = 5'h01;
      tick(LAT);
      n_total++;
      if (irq !== 8'h01) $display("FAIL sim_flag0: got %h want 01", irq);
      else n_pass++;
      src_req = 5'h00;
      tick(LAT + 1);
      n_total++;
      if (irq !== 8'h01) $display("FAIL sticky_after_fall: got %h want 01", irq);
      else n_pass++;
      // Rise lands on the same edge as the acknowledge.
      src_req = 5'h01;
      tick(LAT - 1);
      iack = 8'h01;
      tick(1);
      iack = 8'h00;
      n_total++;
      if (irq !== 8'h01) $display("FAIL set_beats_ack: got %h want 01", irq);
      else n_pass++;
      n_total++;
      if (ovf !== 5'h00) $display("FAIL no_ovf_when_acked: got %h want 00", ovf);
      else n_pass++;
      // Rise of bit 4 lands on the same edge as a clearing write.
      src_req = 5'h11;
      tick(LAT - 1);
      if_we  = 1'b1;
      if_din = 8'h00;
      tick(1);
      if_we  = 1'b0;
      n_total++;
      if (irq !== 8'h10) $display("FAIL set_beats_write: got %h want 10", irq);
      else n_pass++;
      cleanup();
   endtask

   task automatic test_cpu_access();
      cpu_write(8'hFF);
      n_total++;
      if (if_dout !== 8'hFF) $display("FAIL wr_ff_dout: got %h want ff", if_dout);
      else n_pass++;
      n_total++;
      if (irq !== 8'h1F) $display("FAIL wr_ff_irq: got %h want 1f", irq);
      else n_pass++;
      cpu_write(8'h0A);
      n_total++;
      if (if_dout !== 8'hEA) $display("FAIL wr_0a_dout: got %h want ea", if_dout);
      else n_pass++;
      n_total++;
      if (irq !== 8'h0A) $display("FAIL wr_0a_irq: got %h want 0a", irq);
      else n_pass++;
      iack = 8'h80;
      tick(1);
      iack = 8'h00;
      n_total++;
      if (irq !== 8'h0A) $display("FAIL iack_hi_ignored: got %h want 0a", irq);
      else n_pass++;
      // Multi-hot acknowledge clears every named bit.
      iack = 8'h0A;
      tick(1);
      iack = 8'h00;
      n_total++;
      if (if_dout !== 8'hE0) $display("FAIL iack_multi: got %h want e0", if_dout);
      else n_pass++;
      cleanup();
   endtask

   task automatic test_overflow();
      src_req = 5'h08;
      tick(LAT);
      n_total++;
      if (irq !== 8'h08) $display("FAIL ovf_first_set: got %h want 08", irq);
      else n_pass++;
      n_total++;
      if (ovf !== 5'h00) $display("FAIL ovf_not_yet: got %h want 00", ovf);
      else n_pass++;
      src_req = 5'h00;
      tick(LAT + 1);
      src_req = 5'h08;
      tick(LAT);
      n_total++;
      if (ovf !== 5'h08) $display("FAIL ovf_second_rise: got %h want 08", ovf);
      else n_pass++;
      n_total++;
      if (irq !== 8'h08) $display("FAIL ovf_irq_kept: got %h want 08", irq);
      else n_pass++;
      cpu_write(8'h08);
      n_total++;
      if (ovf !== 5'h00) $display("FAIL ovf_clear_by_write: got %h want 00", ovf);
      else n_pass++;
      n_total++;
      if (irq !== 8'h08) $display("FAIL ovf_write_keeps_flag: got %h want 08", irq);
      else n_pass++;
      cleanup();
   endtask

   task automatic test_reset_mid();
      cpu_write(8'h15);
      n_total++;
      if (irq !== 8'h15) $display("FAIL mid_flags: got %h want 15", irq);
      else n_pass++;
      src_req = 5'h01;
      tick(LAT);
      n_total++;
      if (ovf !== 5'h01) $display("FAIL mid_ovf_pre: got %h want 01", ovf);
      else n_pass++;
      #2;
      reset_n = 1'b0;
      #1;
      n_total++;
      if (irq !== 8'h00) $display("FAIL mid_async_irq: got %h want 00", irq);
      else n_pass++;
      n_total++;
      if (ovf !== 5'h00) $display("FAIL mid_async_ovf: got %h want 00", ovf);
      else n_pass++;
      n_total++;
      if (if_dout !== 8'hE0) $display("FAIL mid_async_dout: got %h want e0", if_dout);
      else n_pass++;
      tick(1);
      reset_n = 1'b1;
      tick(LAT);
      n_total++;
      if (irq !== 8'h01) $display("FAIL mid_release_set: got %h want 01", irq);
      else n_pass++;
      cleanup();
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_req_ack();
      test_simultaneous();
      test_cpu_access();
      test_overflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
